// File: rtl/can_mux_bus_ctrl.sv
// Host-to-CAN bridge for one or more controllers that share a multiplexed
// 8-bit address/data bus. Each access is one ALE / address-hold / strobe /
// CS-hold sequence. Each phase has a programmable length. The block also
// produces a controller reset pulse and synchronizes the interrupt lines.
module can_mux_bus_ctrl #(
  parameter int NUM_DEV    = 2,
  parameter int ADDR_SHIFT = 2,
  parameter int T_ALE      = 3,
  parameter int T_AS       = 1,
  parameter int T_STB      = 4,
  parameter int T_HOLD     = 1,
  parameter int T_RST      = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        addr_32b_i,
  input  logic               wren_i,
  input  logic               rden_i,
  input  logic [31:0]        din_32b_i,
  input  logic               rst_req_i,
  output logic [31:0]        dout_32b_o,
  output logic               dout_32b_valid_o,
  output logic               busy_o,
  input  logic [7:0]         can_ad_i,
  output logic [7:0]         can_ad_o,
  output logic               can_ad_sel,
  output logic               can_ale,
  output logic               can_wr_n,
  output logic               can_rd_n,
  output logic               can_rst_n,
  output logic [NUM_DEV-1:0] can_cs_n,
  input  logic [NUM_DEV-1:0] can_int_n,
  output logic [NUM_DEV-1:0] irq_o
);

  localparam int DEV_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  // Each phase counter is loaded with (length - 1) and the phase ends when it reaches 0.
  localparam logic [7:0] CNT_ALE  = 8'(T_ALE - 1);
  localparam logic [7:0] CNT_AS   = 8'(T_AS - 1);
  localparam logic [7:0] CNT_STB  = 8'(T_STB - 1);
  localparam logic [7:0] CNT_HOLD = 8'(T_HOLD - 1);
  localparam logic [7:0] CNT_RST  = 8'(T_RST - 1);

  typedef enum logic [2:0] {
    ST_RST,
    ST_IDLE,
    ST_ALE,
    ST_AHOLD,
    ST_STB,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t             state_reg;
  logic [7:0]         cnt_reg;
  logic               rd_reg;
  logic [DEV_W-1:0]   dev_reg;
  logic [7:0]         data_reg;
  logic               rst_pend_reg;
  logic [NUM_DEV-1:0] irq_meta_reg;

  logic [7:0]         req_index;
  logic [DEV_W-1:0]   req_dev;
  logic [NUM_DEV-1:0] dev_sel;
  logic               dev_ok;

  // Only din[7:0] and the index/device bits of the address are meaningful.
  wire unused_ok = ^{din_32b_i[31:8], addr_32b_i};

  assign req_index = addr_32b_i[ADDR_SHIFT +: 8];

  // The device field sits directly above the register index. A single device has no field.
  generate
    if (NUM_DEV > 1) begin : g_dev_field
      assign req_dev = addr_32b_i[ADDR_SHIFT + 8 +: DEV_W];
    end else begin : g_no_dev_field
      assign req_dev = '0;
    end
  endgenerate

  // One-hot decode of the latched device. An out-of-range device selects nothing.
  generate
    for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_dev_sel
      assign dev_sel[gi] = (dev_reg == DEV_W'(gi));
    end
  endgenerate

  assign dev_ok = |dev_sel;

  // Interrupt lines: two-flop synchronizer. The output is active-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_meta_reg <= '0;
      irq_o        <= '0;
    end else begin
      irq_meta_reg <= ~can_int_n;
      irq_o        <= irq_meta_reg;
    end
  end

  // Bus sequencer: phase state, phase counter and all registered bus/host outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_RST;
      cnt_reg          <= CNT_RST;
      rd_reg           <= 1'b0;
      dev_reg          <= '0;
      data_reg         <= 8'h00;
      rst_pend_reg     <= 1'b0;
      can_ad_o         <= 8'h00;
      can_ad_sel       <= 1'b0;
      can_ale          <= 1'b0;
      can_wr_n         <= 1'b1;
      can_rd_n         <= 1'b1;
      can_rst_n        <= 1'b0;
      can_cs_n         <= '1;
      dout_32b_o       <= 32'h0;
      dout_32b_valid_o <= 1'b0;
      busy_o           <= 1'b1;
    end else begin
      dout_32b_valid_o <= 1'b0;

      // A soft reset requested mid-transaction waits until the access finishes.
      if (rst_req_i && (state_reg != ST_IDLE) && (state_reg != ST_RST)) begin
        rst_pend_reg <= 1'b1;
      end

      case (state_reg)
        ST_RST: begin
          if (cnt_reg == 8'd0) begin
            can_rst_n <= 1'b1;
            busy_o    <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end

        ST_IDLE: begin
          if (rst_req_i) begin
            // A reset request beats any access in the same cycle. The access is dropped.
            can_rst_n <= 1'b0;
            cnt_reg   <= CNT_RST;
            busy_o    <= 1'b1;
            state_reg <= ST_RST;
          end else if (wren_i || rden_i) begin
            rd_reg     <= rden_i;
            dev_reg    <= req_dev;
            data_reg   <= din_32b_i[7:0];
            can_ale    <= 1'b1;
            can_ad_o   <= req_index;
            can_ad_sel <= 1'b0;
            cnt_reg    <= CNT_ALE;
            busy_o     <= 1'b1;
            state_reg  <= ST_ALE;
          end
        end

        ST_ALE: begin
          if (cnt_reg == 8'd0) begin
            can_ale   <= 1'b0;
            cnt_reg   <= CNT_AS;
            state_reg <= ST_AHOLD;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end

        ST_AHOLD: begin
          if (cnt_reg == 8'd0) begin
            can_cs_n <= ~dev_sel;
            if (rd_reg) begin
              can_rd_n   <= 1'b0;
              can_ad_sel <= 1'b1;
              can_ad_o   <= 8'h00;
            end else begin
              can_wr_n <= 1'b0;
              can_ad_o <= data_reg;
            end
            cnt_reg   <= CNT_STB;
            state_reg <= ST_STB;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end

        ST_STB: begin
          if (cnt_reg == 8'd0) begin
            can_rd_n <= 1'b1;
            can_wr_n <= 1'b1;
            // Read data is sampled on the last strobe edge. If no device was selected, the read returns 0.
            if (rd_reg) begin
              dout_32b_o <= {24'h0, dev_ok ? can_ad_i : 8'h00};
            end
            cnt_reg   <= CNT_HOLD;
            state_reg <= ST_HOLD;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end

        ST_HOLD: begin
          if (cnt_reg == 8'd0) begin
            can_cs_n         <= '1;
            can_ad_sel       <= 1'b0;
            can_ad_o         <= 8'h00;
            dout_32b_valid_o <= 1'b1;
            state_reg        <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end

        ST_DONE: begin
          if (rst_pend_reg || rst_req_i) begin
            rst_pend_reg <= 1'b0;
            can_rst_n    <= 1'b0;
            cnt_reg      <= CNT_RST;
            state_reg    <= ST_RST;
          end else begin
            busy_o    <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          busy_o    <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
